// File: rtl/regfile_sb.sv
// Register file with two read ports, two write ports and a busy scoreboard.
// All state updates on the falling edge of CLK; decode reads combinationally in the high phase.
module regfile_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              Busy1,
  output logic              Busy2,
  input  logic              WE0,
  input  logic [ADDR_W-1:0] WA0,
  input  logic [DATA_W-1:0] WD0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] WA1,
  input  logic [DATA_W-1:0] WD1,
  input  logic              Reserve,
  input  logic [ADDR_W-1:0] ResvReg,
  output logic              WawHazard,
  output logic [ADDR_W:0]   BusyCount,
  input  logic [ADDR_W-1:0] DbgReg,
  output logic [DATA_W-1:0] DbgData
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  sb;
  logic [DEPTH-1:0]  sb_next;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_next;

  logic eff0, eff1, wr0, res_eff;
  logic set_inc, clr0, clr1;

  function automatic logic hits(input logic en, input logic [ADDR_W-1:0] wa,
                                input logic [ADDR_W-1:0] ra);
    return en && (wa == ra);
  endfunction

  assign eff0    = WE0 && (WA0 != '0);
  assign eff1    = WE1 && (WA1 != '0);
  // Port 1 wins an address collision, so port 0 is dropped entirely.
  assign wr0     = eff0 && !(eff1 && (WA1 == WA0));
  assign res_eff = Reserve && (ResvReg != '0);

  logic [DATA_W-1:0] stored1, stored2;
  logic byp0_1, byp1_1, byp0_2, byp1_2;

  assign stored1 = (ReadReg1 == '0) ? '0 : regs[ReadReg1];
  assign stored2 = (ReadReg2 == '0) ? '0 : regs[ReadReg2];

  assign byp1_1 = BYPASS && hits(eff1, WA1, ReadReg1);
  assign byp0_1 = BYPASS && hits(eff0, WA0, ReadReg1);
  assign byp1_2 = BYPASS && hits(eff1, WA1, ReadReg2);
  assign byp0_2 = BYPASS && hits(eff0, WA0, ReadReg2);

  assign ReadData1 = byp1_1 ? WD1 : (byp0_1 ? WD0 : stored1);
  assign ReadData2 = byp1_2 ? WD1 : (byp0_2 ? WD0 : stored2);

  // A forwarded write satisfies the consumer, so its busy bit is hidden.
  assign Busy1 = sb[ReadReg1] && !(byp0_1 || byp1_1);
  assign Busy2 = sb[ReadReg2] && !(byp0_2 || byp1_2);

  assign WawHazard = res_eff && sb[ResvReg];
  assign BusyCount = count;
  assign DbgData   = (DbgReg == '0) ? '0 : regs[DbgReg];

  always_comb begin
    sb_next = sb;
    if (eff0)    sb_next[WA0]     = 1'b0;
    if (eff1)    sb_next[WA1]     = 1'b0;
    if (res_eff) sb_next[ResvReg] = 1'b1;
    sb_next[0] = 1'b0;
  end

  // Incremental count: a cleared bit only counts once and never when re-reserved.
  assign set_inc = res_eff && !sb[ResvReg];
  assign clr0    = wr0  && sb[WA0] && !(res_eff && (ResvReg == WA0));
  assign clr1    = eff1 && sb[WA1] && !(res_eff && (ResvReg == WA1));
  assign count_next = count + (ADDR_W + 1)'(set_inc)
                            - (ADDR_W + 1)'(clr0)
                            - (ADDR_W + 1)'(clr1);

  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
      sb    <= '0;
      count <= '0;
    end else begin
      if (wr0)  regs[WA0] <= WD0;
      if (eff1) regs[WA1] <= WD1;
      sb    <= sb_next;
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a forwarding and a non-forwarding instance share one stimulus
// stream and are checked every cycle against an array/bit-list model of the register file.
`timescale 1ns/1ps
module tb_regfile_sb;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #10 clk = ~clk;

  logic [AW-1:0] rr1, rr2, wa0, wa1, resv_reg, dbg;
  logic          we0, we1, resv;
  logic [DW-1:0] wd0, wd1;

  logic [DW-1:0] rd1_a, rd2_a, dbg_a, rd1_b, rd2_b, dbg_b;
  logic          busy1_a, busy2_a, waw_a, busy1_b, busy2_b, waw_b;
  logic [AW:0]   cnt_a, cnt_b;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b1)) dut_a (
    .CLK(clk), .RST(rst_n),
    .ReadReg1(rr1), .ReadReg2(rr2), .ReadData1(rd1_a), .ReadData2(rd2_a),
    .Busy1(busy1_a), .Busy2(busy2_a),
    .WE0(we0), .WA0(wa0), .WD0(wd0), .WE1(we1), .WA1(wa1), .WD1(wd1),
    .Reserve(resv), .ResvReg(resv_reg), .WawHazard(waw_a), .BusyCount(cnt_a),
    .DbgReg(dbg), .DbgData(dbg_a)
  );

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b0)) dut_b (
    .CLK(clk), .RST(rst_n),
    .ReadReg1(rr1), .ReadReg2(rr2), .ReadData1(rd1_b), .ReadData2(rd2_b),
    .Busy1(busy1_b), .Busy2(busy2_b),
    .WE0(we0), .WA0(wa0), .WD0(wd0), .WE1(we1), .WA1(wa1), .WD1(wd1),
    .Reserve(resv), .ResvReg(resv_reg), .WawHazard(waw_b), .BusyCount(cnt_b),
    .DbgReg(dbg), .DbgData(dbg_b)
  );

  int n_vec = 0;
  int n_err = 0;
  bit run   = 1'b0;

  // behavioural model
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_sb  [DEPTH];

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_sb[i]  = 1'b0;
    end
  endtask

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) model_clear();
    else begin
      if (we0 && wa0 != 0) m_mem[wa0] = wd0;
      if (we1 && wa1 != 0) m_mem[wa1] = wd1;
      if (we0 && wa0 != 0) m_sb[wa0] = 1'b0;
      if (we1 && wa1 != 0) m_sb[wa1] = 1'b0;
      if (resv && resv_reg != 0) m_sb[resv_reg] = 1'b1;
    end
  end

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    logic [DW-1:0] v;
    v = (a == 0) ? '0 : m_mem[a];
    if (byp && a != 0) begin
      if (we0 && wa0 == a) v = wd0;
      if (we1 && wa1 == a) v = wd1;
    end
    return v;
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
    logic b;
    b = m_sb[a];
    if (byp && a != 0 && ((we0 && wa0 == a) || (we1 && wa1 == a))) b = 1'b0;
    return b;
  endfunction

  function automatic logic [AW:0] exp_cnt();
    int c;
    c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_sb[i]);
    return (AW + 1)'(c);
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic waw_e;
    waw_e = resv && resv_reg != 0 && m_sb[resv_reg];
    chk("a.rd1",   rd1_a,             exp_rd(rr1, 1'b1));
    chk("a.rd2",   rd2_a,             exp_rd(rr2, 1'b1));
    chk("a.busy1", 32'(busy1_a),      32'(exp_busy(rr1, 1'b1)));
    chk("a.busy2", 32'(busy2_a),      32'(exp_busy(rr2, 1'b1)));
    chk("a.waw",   32'(waw_a),        32'(waw_e));
    chk("a.cnt",   32'(cnt_a),        32'(exp_cnt()));
    chk("a.dbg",   dbg_a,             (dbg == 0) ? '0 : m_mem[dbg]);
    chk("b.rd1",   rd1_b,             exp_rd(rr1, 1'b0));
    chk("b.rd2",   rd2_b,             exp_rd(rr2, 1'b0));
    chk("b.busy1", 32'(busy1_b),      32'(exp_busy(rr1, 1'b0)));
    chk("b.busy2", 32'(busy2_b),      32'(exp_busy(rr2, 1'b0)));
    chk("b.waw",   32'(waw_b),        32'(waw_e));
    chk("b.cnt",   32'(cnt_b),        32'(exp_cnt()));
    chk("b.dbg",   dbg_b,             (dbg == 0) ? '0 : m_mem[dbg]);
  endtask

  always @(posedge clk) begin
    if (run) begin
      #4;
      check_all();
    end
  end

  // driver tasks
  task automatic begin_cycle();
    @(posedge clk);
    #1;
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    resv = 1'b0; resv_reg = '0;
    rr1 = '0; rr2 = '0; dbg = '0;
  endtask

  initial begin
    model_clear();
    rst_n = 1'b0;
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    resv = 1'b0; resv_reg = '0;
    rr1 = '0; rr2 = '0; dbg = '0;
    repeat (2) @(posedge clk);

    begin_cycle(); rst_n = 1'b1; run = 1'b1; rr1 = 5'd3; dbg = 5'd3; #5;
    chk("rst.rd1",   rd1_a,        32'h0);
    chk("rst.dbg",   dbg_a,        32'h0);
    chk("rst.busy1", 32'(busy1_a), 32'd0);
    chk("rst.cnt",   32'(cnt_a),   32'd0);

    // single write, forwarded same cycle on a, stored after the edge
    begin_cycle(); we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hDEADBEEF; rr1 = 5'd3; dbg = 5'd3; #5;
    chk("byp.rd1",    rd1_a, 32'hDEADBEEF);
    chk("byp.dbg",    dbg_a, 32'h0);
    chk("nobyp.rd1",  rd1_b, 32'h0);
    begin_cycle(); rr1 = 5'd3; dbg = 5'd3; #5;
    chk("r3.rd1_a", rd1_a, 32'hDEADBEEF);
    chk("r3.rd1_b", rd1_b, 32'hDEADBEEF);
    chk("r3.dbg",   dbg_a, 32'hDEADBEEF);

    // write collision, and writes to r0
    begin_cycle(); we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11; we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22; rr1 = 5'd7; #5;
    chk("coll.rd1_a", rd1_a, 32'h22);
    begin_cycle(); rr1 = 5'd7; dbg = 5'd7; we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF; #5;
    chk("coll.rd1_b", rd1_b, 32'h22);
    chk("coll.dbg",   dbg_a, 32'h22);
    chk("r0.rd2_a",   rd2_a, 32'h0);
    begin_cycle(); #5;
    chk("r0.rd2_after", rd2_a, 32'h0);
    chk("r0.dbg_after", dbg_b, 32'h0);

    // reserve r5, then release it via port 1
    begin_cycle(); resv = 1'b1; resv_reg = 5'd5; rr1 = 5'd5; #5;
    chk("r5.busy_pre", 32'(busy1_a), 32'd0);
    chk("r5.cnt_pre",  32'(cnt_a),   32'd0);
    begin_cycle(); rr1 = 5'd5; #5;
    chk("r5.busy_a", 32'(busy1_a), 32'd1);
    chk("r5.busy_b", 32'(busy1_b), 32'd1);
    chk("r5.cnt",    32'(cnt_a),   32'd1);
    begin_cycle(); we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h55; rr1 = 5'd5; rr2 = 5'd5; #5;
    chk("r5.mask_a",   32'(busy1_a), 32'd0);
    chk("r5.fwd_a",    rd1_a,        32'h55);
    chk("r5.nomask_b", 32'(busy2_b), 32'd1);
    chk("r5.old_b",    rd2_b,        32'h0);
    chk("r5.cnt_hold", 32'(cnt_a),   32'd1);
    begin_cycle(); rr1 = 5'd5; #5;
    chk("r5.clear",  32'(busy1_a), 32'd0);
    chk("r5.cnt0",   32'(cnt_a),   32'd0);
    chk("r5.data_b", rd1_b,        32'h55);

    // reserve r9 alongside a write to r9, then re-reserve
    begin_cycle(); resv = 1'b1; resv_reg = 5'd9; #5;
    chk("r9.waw0", 32'(waw_a), 32'd0);
    begin_cycle(); resv = 1'b1; resv_reg = 5'd9; we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99; rr1 = 5'd9; #5;
    chk("r9.cnt_mid", 32'(cnt_a), 32'd1);
    begin_cycle(); resv = 1'b1; resv_reg = 5'd9; rr1 = 5'd9; #5;
    chk("r9.busy", 32'(busy1_a), 32'd1);
    chk("r9.cnt",  32'(cnt_a),   32'd1);
    chk("r9.waw",  32'(waw_a),   32'd1);
    chk("r9.data", rd1_a,        32'h99);
    begin_cycle(); we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h9A; #5;
    begin_cycle(); #5;
    chk("r9.cnt_rel", 32'(cnt_a), 32'd0);

    // three reserves, double release, then asynchronous reset mid-cycle
    for (int i = 1; i <= 3; i++) begin
      begin_cycle(); resv = 1'b1; resv_reg = AW'(i);
    end
    begin_cycle(); we0 = 1'b1; wa0 = 5'd1; wd0 = 32'h101; we1 = 1'b1; wa1 = 5'd2; wd1 = 32'h202; #5;
    chk("r123.cnt_a", 32'(cnt_a), 32'd3);
    chk("r123.cnt_b", 32'(cnt_b), 32'd3);
    begin_cycle(); rr1 = 5'd3; rr2 = 5'd1; dbg = 5'd3; #5;
    chk("r123.cnt1",  32'(cnt_a),   32'd1);
    chk("r123.busy3", 32'(busy1_a), 32'd1);
    chk("r123.rd_r1", rd2_a,        32'h101);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.cnt_a", 32'(cnt_a),   32'd0);
    chk("arst.cnt_b", 32'(cnt_b),   32'd0);
    chk("arst.rd1",   rd1_a,        32'h0);
    chk("arst.rd2",   rd2_a,        32'h0);
    chk("arst.dbg",   dbg_a,        32'h0);
    chk("arst.busy",  32'(busy1_a), 32'd0);
    begin_cycle(); we0 = 1'b1; wa0 = 5'd6; wd0 = 32'h66; rr1 = 5'd6; resv = 1'b1; resv_reg = 5'd6; #5;
    chk("inrst.fwd_a", rd1_a, 32'h66);
    chk("inrst.rd_b",  rd1_b, 32'h0);
    begin_cycle(); rst_n = 1'b1; rr1 = 5'd6; #5;
    chk("inrst.lost",  rd1_a,        32'h0);
    chk("inrst.busy",  32'(busy1_a), 32'd0);
    chk("inrst.cnt",   32'(cnt_a),   32'd0);

    // non-forwarding build: old data and unmasked busy during the write
    begin_cycle(); resv = 1'b1; resv_reg = 5'd4;
    begin_cycle(); we0 = 1'b1; wa0 = 5'd4; wd0 = 32'hA5; rr1 = 5'd4; rr2 = 5'd4; #5;
    chk("r4.old_b",  rd1_b,        32'h0);
    chk("r4.busy_b", 32'(busy2_b), 32'd1);
    chk("r4.fwd_a",  rd1_a,        32'hA5);
    chk("r4.mask_a", 32'(busy2_a), 32'd0);
    begin_cycle(); rr1 = 5'd4; rr2 = 5'd4; #5;
    chk("r4.new_b",  rd1_b,        32'hA5);
    chk("r4.clr_b",  32'(busy2_b), 32'd0);

    // fill sweep with mixed reserves and collisions; the compare process checks each cycle
    for (int i = 1; i < DEPTH; i++) begin
      begin_cycle();
      we0 = 1'b1; wa0 = AW'(i); wd0 = DW'(i) * 32'h01010101;
      we1 = (i % 3 == 0); wa1 = AW'(DEPTH - 1 - i); wd1 = ~(DW'(i) * 32'h00010001);
      resv = (i % 4 != 1); resv_reg = AW'((i * 7) % DEPTH);
      rr1 = AW'(i); rr2 = AW'(DEPTH - 1 - i); dbg = AW'(i - 1);
    end
    for (int i = 0; i < DEPTH; i += 3) begin
      begin_cycle();
      rr1 = AW'(i); rr2 = AW'(i + 1); dbg = AW'(i + 2);
    end
    repeat (2) begin_cycle();
    #5;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file for the multi-cycle CPU, with two read ports, two write ports and a per-register scoreboard. The scoreboard tracks registers reserved by in-flight multi-cycle producers such as the multiplier/divider and memory loads. It sits between the decode stage, which reads and reserves, and the writeback stage, which writes and releases. Register 0 is hardwired to zero and is never busy.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W entries, entry 0 constant zero
- BYPASS, 1, 1 = same-cycle write-to-read forwarding and busy masking; 0 = none
- CLK  in  1  clock; all state updates on the falling edge
- RST  in  1  reset, asynchronous, active-low
- ReadReg1, ReadReg2  in  ADDR_W  read addresses
- ReadData1, ReadData2  out  DATA_W  combinational read data
- Busy1, Busy2  out  1  scoreboard status of ReadReg1 / ReadReg2
- WE0, WA0, WD0  in  1/ADDR_W/DATA_W  write port 0 (ALU writeback)
- WE1, WA1, WD1  in  1/ADDR_W/DATA_W  write port 1 (load / mul-div writeback)
- Reserve, ResvReg  in  1/ADDR_W  mark ResvReg busy at the next falling edge
- WawHazard  out  1  Reserve asserted while ResvReg is already busy
- BusyCount  out  ADDR_W+1  number of busy registers
- DbgReg  in  ADDR_W  debug read address
- DbgData  out  DATA_W  raw stored value of DbgReg, never bypassed

## Operation
- Storage: entries 1..2**ADDR_W-1. Reads of address 0 return 0, and writes to address 0 are discarded.
- Write resolution: a write port is effective when WEn=1 and WAn≠0. If both ports are effective on the same address, port 1 wins and port 0 is dropped.
- Read, BYPASS=1: if the read address equals an effective write address this cycle, ReadData returns the winning write data. Otherwise it returns the stored value.
- Read, BYPASS=0: ReadData always returns the stored value.
- Scoreboard: one bit per entry; bit 0 is permanently 0.
  - An effective write clears the bit of its address.
  - Reserve with ResvReg≠0 sets the bit of ResvReg.
  - Reserve and an effective write to the same register in the same cycle: the reserve wins and the bit ends at 1 (newer producer).
  - Reserve of register 0 is ignored.
- Busy outputs:
  - Busyn is the scoreboard bit of ReadRegn.
  - With BYPASS=1, Busyn is forced to 0 when an effective write targets ReadRegn this cycle, because the data is forwarded.
  - A reserve in the current cycle does not affect Busy until after the edge.
- WawHazard = Reserve & (ResvReg≠0) & sb[ResvReg], combinational. This is informational only; the bit stays set.
- BusyCount: a registered population count of the scoreboard, updated at the same edge as the bits. Its net change per edge is the count of bits set minus the count of bits cleared, in the range -2..+1. It must always equal the popcount of the scoreboard.

## Timing
- Register and scoreboard updates happen on the falling edge of CLK. Decode reads combinationally during the following high phase.
- Write-to-read latency is 0 with BYPASS=1 (same cycle) and visible after the falling edge with BYPASS=0.
- Reserve-to-Busy latency: visible after the falling edge that samples Reserve.
- Reset (RST=0), asynchronous, effective immediately, including mid-operation:
  - all entries = 0, all scoreboard bits = 0, BusyCount = 0
  - ReadData1/2 and DbgData = 0 unless bypassing a write
  - Busy1/2 = 0, WawHazard follows its inputs (0 because the scoreboard is clear)
  - Writes and reserves presented during reset are lost.
- After RST deasserts, the first falling edge performs normal updates.

## Test plan
- Reset, then WE0=1, WA0=3, WD0=0xDEADBEEF; read r3 → same-cycle ReadData1=0xDEADBEEF (BYPASS=1), stored value after the edge, DbgData=0 before the edge.
- Dual write with WA0=WA1=7, WD0=0x11, WD1=0x22 → r7=0x22; write to r0 with 0xFFFF → ReadData of r0 stays 0.
- Reserve r5 → Busy=1 and BusyCount=1 after the edge. Then WE1 to r5 with 0x55 → in that cycle Busy=0 and ReadData=0x55; after the edge bit clear and BusyCount=0.
- Reserve r9 and write r9 in the same cycle → bit remains 1, BusyCount unchanged from the prior reserve. A second reserve of r9 → WawHazard=1.
- Reserve r1, r2, r3 in successive cycles (BusyCount=3), then write r1 and r2 in one cycle → BusyCount=1. Assert RST mid-cycle → BusyCount=0 and all reads 0 immediately.
- BYPASS=0 build: write r4=0xA5 → same-cycle ReadData=old value, 0xA5 after the falling edge; Busy not masked during the write cycle.
